// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and forwarding-select generation for the 5-stage core.
// Keeps shadow copies of the E/M/W write records and the mult/div busy window.
module hazard_fwd_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_dst,
    input  logic [1:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    output logic       stall,
    output logic [1:0] d_fwd_rs,
    output logic [1:0] d_fwd_rt,
    output logic [1:0] e_fwd_rs,
    output logic [1:0] e_fwd_rt,
    output logic       m_fwd_rt,
    output logic       md_busy
);

    logic [4:0] e_dst, e_rs, e_rt;
    logic [1:0] e_tnew;
    logic       e_md_start, e_md_div;
    logic [4:0] m_dst, m_rt;
    logic [1:0] m_tnew;
    logic [4:0] w_dst;
    logic [1:0] w_tnew;
    logic [3:0] md_cnt;

    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Register 0 is hard-wired, so it never participates in a dependency.
    function automatic logic hit(input logic [4:0] s, input logic [4:0] dst);
        return (s != 5'd0) && (s == dst);
    endfunction

    function automatic logic [1:0] d_sel(input logic [4:0] s);
        if (hit(s, e_dst) && e_tnew == 2'd0)
            return 2'b01;
        else if (hit(s, m_dst) && m_tnew == 2'd0)
            return 2'b10;
        else if (hit(s, w_dst) && w_tnew == 2'd0)
            return 2'b11;
        else
            return 2'b00;
    endfunction

    function automatic logic [1:0] e_sel(input logic [4:0] s);
        if (hit(s, m_dst) && m_tnew == 2'd0)
            return 2'b01;
        else if (hit(s, w_dst))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    function automatic logic data_stall(input logic [4:0] s, input logic [1:0] tuse);
        return (hit(s, e_dst) && (e_tnew > tuse)) ||
               (hit(s, m_dst) && (m_tnew > tuse));
    endfunction

    logic md_stall;

    always_comb begin
        md_busy  = (md_cnt != 4'd0);
        md_stall = d_md_use && (md_busy || e_md_start);
        stall    = data_stall(d_rs, d_tuse_rs) | data_stall(d_rt, d_tuse_rt) | md_stall;
        d_fwd_rs = d_sel(d_rs);
        d_fwd_rt = d_sel(d_rt);
        e_fwd_rs = e_sel(e_rs);
        e_fwd_rt = e_sel(e_rt);
        m_fwd_rt = hit(m_rt, w_dst);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_dst      <= '0;
            e_tnew     <= '0;
            e_rs       <= '0;
            e_rt       <= '0;
            e_md_start <= 1'b0;
            e_md_div   <= 1'b0;
            m_dst      <= '0;
            m_tnew     <= '0;
            m_rt       <= '0;
            w_dst      <= '0;
            w_tnew     <= '0;
            md_cnt     <= '0;
        end else begin
            w_dst  <= m_dst;
            w_tnew <= dec_sat(m_tnew);
            m_dst  <= e_dst;
            m_tnew <= dec_sat(e_tnew);
            m_rt   <= e_rt;
            if (stall) begin
                e_dst      <= '0;
                e_tnew     <= '0;
                e_rs       <= '0;
                e_rt       <= '0;
                e_md_start <= 1'b0;
                e_md_div   <= 1'b0;
            end else begin
                e_dst      <= d_dst;
                e_tnew     <= d_tnew;
                e_rs       <= d_rs;
                e_rt       <= d_rt;
                e_md_start <= d_md_start;
                e_md_div   <= d_md_div;
            end
            if (e_md_start)
                md_cnt <= e_md_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
            else if (md_cnt != 4'd0)
                md_cnt <= md_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed-vector bench for hazard_fwd_ctrl: stimulus pushes hand-computed
// expectations into a scoreboard, a monitor pops and compares each cycle.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] d_rs = '0, d_rt = '0, d_dst = '0;
    logic [1:0] d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = '0;
    logic       d_md_start = 1'b0, d_md_div = 1'b0, d_md_use = 1'b0;
    logic       stall, m_fwd_rt, md_busy;
    logic [1:0] d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt;

    hazard_fwd_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .stall(stall), .d_fwd_rs(d_fwd_rs), .d_fwd_rt(d_fwd_rt),
        .e_fwd_rs(e_fwd_rs), .e_fwd_rt(e_fwd_rt), .m_fwd_rt(m_fwd_rt),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    logic [10:0] q_exp[$];
    string       q_nm[$];
    int          errors = 0;
    int          checks = 0;
    logic        rst_lvl = 1'b0;

    // Field order: stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt, m_fwd_rt, md_busy
    function automatic logic [10:0] ex(input logic st, input logic [1:0] drs, input logic [1:0] drt,
                                       input logic [1:0] ers, input logic [1:0] ert,
                                       input logic mrt, input logic bz);
        return {st, drs, drt, ers, ert, mrt, bz};
    endfunction

    task automatic cyc(input string nm,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] urs, input logic [1:0] urt,
                       input logic [4:0] dst, input logic [1:0] tn,
                       input logic mds, input logic mdd, input logic mdu,
                       input logic [10:0] expv);
        @(posedge clk);
        #1;
        rst_n      = rst_lvl;
        d_rs       = rs;
        d_rt       = rt;
        d_tuse_rs  = urs;
        d_tuse_rt  = urt;
        d_dst      = dst;
        d_tnew     = tn;
        d_md_start = mds;
        d_md_div   = mdd;
        d_md_use   = mdu;
        q_exp.push_back(expv);
        q_nm.push_back(nm);
    endtask

    task automatic idle(input string nm, input logic [10:0] expv);
        cyc(nm, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, expv);
    endtask

    initial begin : monitor
        logic [10:0] act, e;
        string       nm;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e   = q_exp.pop_front();
                nm  = q_nm.pop_front();
                act = {stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt, m_fwd_rt, md_busy};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b (stall,d_rs,d_rt,e_rs,e_rt,m_rt,busy)",
                             nm, act, e);
                end
            end
        end
    end

    initial begin : stim
        logic [10:0] z;
        int          waited;
        z = '0;

        // Reset: records are empty so even a live D read produces nothing.
        cyc("reset", 5'd8, 5'd8, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, z);
        rst_lvl = 1'b1;

        // Load-use: lw $8 then addu $9,$8
        cyc("lu_lw_in_d", 5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0, z);
        cyc("lu_stall", 5'd8, 5'd0, 2'd1, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0, ex(1, 0, 0, 0, 0, 0, 0));
        cyc("lu_release", 5'd8, 5'd0, 2'd1, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0, z);
        idle("lu_e_fwd_w", ex(0, 0, 0, 2'b10, 0, 0, 0));
        idle("drain1", z);

        // ALU chain: addu $3 then beq $3,$0
        cyc("alu_in_d", 5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0, z);
        cyc("alu_stall", 5'd3, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, ex(1, 0, 0, 0, 0, 0, 0));
        cyc("alu_d_fwd_m", 5'd3, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, ex(0, 2'b10, 0, 0, 0, 0, 0));

        // jal then jr $31; beq (now in E) also picks $3 from W
        cyc("jal_beq_e_w", 5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 2'b10, 0, 0, 0));
        cyc("jr_d_fwd_e", 5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, ex(0, 2'b01, 0, 0, 0, 0, 0));
        idle("jr_e_fwd_m", ex(0, 0, 0, 2'b01, 0, 0, 0));

        // Zero register never matches
        cyc("zero_lw0_in_d", 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0, z);
        cyc("zero_read", 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, z);

        // Priority: writers of $7 then two writers of $5
        cyc("pri_w7", 5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd0, 1'b0, 1'b0, 1'b0, z);
        cyc("pri_d_rt_e", 5'd0, 5'd7, 2'd3, 2'd2, 5'd5, 2'd0, 1'b0, 1'b0, 1'b0, ex(0, 0, 2'b01, 0, 0, 0, 0));
        cyc("pri_e_rt_m", 5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd0, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 2'b01, 0, 0));
        cyc("pri_e_over_m", 5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, ex(0, 2'b01, 0, 0, 0, 1, 0));
        idle("pri_m_over_w", ex(0, 0, 0, 2'b01, 0, 0, 0));

        // div followed by mfhi: 11 stall cycles, 10 busy cycles
        cyc("md_div_in_d", 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1, z);
        cyc("md_div_in_e", 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1, ex(1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            cyc("md_div_busy", 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1, ex(1, 0, 0, 0, 0, 0, 1));
        cyc("md_div_done", 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1, z);

        // mult then mflo, with reset asserted mid-window
        cyc("md_mult_in_d", 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1, z);
        cyc("md_mult_in_e", 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1, ex(1, 0, 0, 0, 0, 0, 0));
        cyc("md_mult_busy5", 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1, ex(1, 0, 0, 0, 0, 0, 1));
        cyc("md_mult_busy4", 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1, ex(1, 0, 0, 0, 0, 0, 1));
        rst_lvl = 1'b0;
        cyc("md_async_rst", 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1, z);
        cyc("md_rst_hold", 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1, z);
        rst_lvl = 1'b1;
        idle("post_rst", z);

        waited = 0;
        while (q_exp.size() > 0 && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (q_exp.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expected 0 pending", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
